despacho_sr: RTL

- Dispatch scheduler for one reservation-station class (R-type or I-type) of the Tomasulo core.
- Accepts issued instructions from the instruction queue into NUM_ENT entries and snoops the CDB to resolve operand tags.
- Selects one ready entry per cycle and launches it into its unidadeFuncional using the nova/UF_atoa handshake.
- Replaces the per-class scheduling logic inside estacaoReserva; one instance is built per functional unit.

---
 rtl/despacho_sr.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/despacho_sr.sv
// despacho_sr: per-functional-unit dispatch scheduler for one reservation-station class.
// Define DESPACHO_RR_EN for round-robin selection; the default is fixed lowest-index priority.
module despacho_sr #(
  parameter int NUM_ENT  = 4,
  parameter int BASE_TAG = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        nv_inst,
  input  logic [1:0]  opcode_in,
  input  logic [15:0] Vj_in,
  input  logic [15:0] Vk_in,
  input  logic [3:0]  Qj_in,
  input  logic [3:0]  Qk_in,
  input  logic [2:0]  dest_in,
  output logic [3:0]  tag_alloc,
  output logic        cheia,
  output logic [3:0]  ocupadas,
  input  logic        nv_adt,
  input  logic [3:0]  adt_Q,
  input  logic [15:0] adt_V,
  input  logic        UF_atoa,
  output logic        nova,
  output logic [1:0]  opcode,
  output logic [15:0] Vj,
  output logic [15:0] Vk,
  output logic [2:0]  dest,
  output logic [3:0]  Qi
);

  localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;

  // Handshake: the unit raises UF_atoa while idle; a launch is a one-cycle nova
  // pulse carrying opcode/Vj/Vk/dest/Qi. UF_atoa lags nova by one cycle, so no
  // launch is attempted in the cycle right after a pulse (nova_q gates it).

  // Entry storage
  logic [NUM_ENT-1:0]        busy_q, busy_d;
  logic [NUM_ENT-1:0][1:0]   op_q,   op_d;
  logic [NUM_ENT-1:0][15:0]  vj_q,   vj_d;
  logic [NUM_ENT-1:0][15:0]  vk_q,   vk_d;
  logic [NUM_ENT-1:0][3:0]   qj_q,   qj_d;
  logic [NUM_ENT-1:0][3:0]   qk_q,   qk_d;
  logic [NUM_ENT-1:0][2:0]   dst_q,  dst_d;

  // Dispatch outputs and occupancy
  logic        nova_q,    nova_d;
  logic [1:0]  out_op_q,  out_op_d;
  logic [15:0] out_vj_q,  out_vj_d;
  logic [15:0] out_vk_q,  out_vk_d;
  logic [2:0]  out_dst_q, out_dst_d;
  logic [3:0]  out_qi_q,  out_qi_d;
  logic [3:0]  ocup_q,    ocup_d;

  logic [NUM_ENT-1:0] ready;
  logic [IDX_W-1:0]   alloc_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               alloc_fire;
  logic               dispatch_fire;
  logic [15:0]        vj_new;
  logic [15:0]        vk_new;
  logic [3:0]         qj_new;
  logic [3:0]         qk_new;

  // Free-entry search: lowest free index wins
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign cheia      = &busy_q;
  assign tag_alloc  = 4'(BASE_TAG) + 4'(alloc_idx);
  assign alloc_fire = nv_inst && !cheia;

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == 4'd0) && (qk_q[i] == 4'd0);
    end
  end

`ifdef DESPACHO_RR_EN
  logic [IDX_W-1:0] rr_q, rr_d;

  // Search from the pointer upward, wrapping; the smallest offset wins
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_ENT - 1; k >= 0; k--) begin
      if (ready[(int'(rr_q) + k) % NUM_ENT]) sel_idx = IDX_W'((int'(rr_q) + k) % NUM_ENT);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (dispatch_fire) begin
      rr_d = (sel_idx == IDX_W'(NUM_ENT - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  assign dispatch_fire = UF_atoa && !nova_q && (|ready);

  // Operands broadcast in the issue cycle are captured directly
  always_comb begin
    vj_new = Vj_in;
    qj_new = Qj_in;
    vk_new = Vk_in;
    qk_new = Qk_in;
    if (nv_adt && (adt_Q != 4'd0)) begin
      if (Qj_in == adt_Q) begin
        vj_new = adt_V;
        qj_new = 4'd0;
      end
      if (Qk_in == adt_Q) begin
        vk_new = adt_V;
        qk_new = 4'd0;
      end
    end
  end

  // Entry next state: CDB snoop, dispatch free, allocation write
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    dst_d  = dst_q;
    if (nv_adt && (adt_Q != 4'd0)) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        if (busy_q[i] && (qj_q[i] == adt_Q)) begin
          vj_d[i] = adt_V;
          qj_d[i] = 4'd0;
        end
        if (busy_q[i] && (qk_q[i] == adt_Q)) begin
          vk_d[i] = adt_V;
          qk_d[i] = 4'd0;
        end
      end
    end
    if (dispatch_fire) busy_d[sel_idx] = 1'b0;
    if (alloc_fire) begin
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = opcode_in;
      vj_d[alloc_idx]   = vj_new;
      vk_d[alloc_idx]   = vk_new;
      qj_d[alloc_idx]   = qj_new;
      qk_d[alloc_idx]   = qk_new;
      dst_d[alloc_idx]  = dest_in;
    end
  end

  // Dispatch outputs hold their last values between launches
  always_comb begin
    nova_d    = dispatch_fire;
    out_op_d  = out_op_q;
    out_vj_d  = out_vj_q;
    out_vk_d  = out_vk_q;
    out_dst_d = out_dst_q;
    out_qi_d  = out_qi_q;
    if (dispatch_fire) begin
      out_op_d  = op_q[sel_idx];
      out_vj_d  = vj_q[sel_idx];
      out_vk_d  = vk_q[sel_idx];
      out_dst_d = dst_q[sel_idx];
      out_qi_d  = 4'(BASE_TAG) + 4'(sel_idx);
    end
  end

  always_comb begin
    ocup_d = ocup_q;
    case ({alloc_fire, dispatch_fire})
      2'b10:   ocup_d = ocup_q + 4'd1;
      2'b01:   ocup_d = ocup_q - 4'd1;
      default: ocup_d = ocup_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= '0;
      op_q      <= '0;
      vj_q      <= '0;
      vk_q      <= '0;
      qj_q      <= '0;
      qk_q      <= '0;
      dst_q     <= '0;
      nova_q    <= 1'b0;
      out_op_q  <= '0;
      out_vj_q  <= '0;
      out_vk_q  <= '0;
      out_dst_q <= '0;
      out_qi_q  <= '0;
      ocup_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      op_q      <= op_d;
      vj_q      <= vj_d;
      vk_q      <= vk_d;
      qj_q      <= qj_d;
      qk_q      <= qk_d;
      dst_q     <= dst_d;
      nova_q    <= nova_d;
      out_op_q  <= out_op_d;
      out_vj_q  <= out_vj_d;
      out_vk_q  <= out_vk_d;
      out_dst_q <= out_dst_d;
      out_qi_q  <= out_qi_d;
      ocup_q    <= ocup_d;
    end
  end

  assign nova     = nova_q;
  assign opcode   = out_op_q;
  assign Vj       = out_vj_q;
  assign Vk       = out_vk_q;
  assign dest     = out_dst_q;
  assign Qi       = out_qi_q;
  assign ocupadas = ocup_q;

endmodule
